// File: rtl/shift_pipe16_if.sv
// Command/result channel bundle for shift_pipe16: valid/ready command in, valid/ready result out.
interface shift_pipe16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_pipe16.sv
// Two-stage valid/ready pipelined 16-bit ROR/ROL/SRL/SRA shifter.
// Every op is one right-rotate of the operand followed by optional fill masking.
module shift_pipe16 (
    input  logic          clk,
    input  logic          rst_n,
    shift_pipe16_if.slave bus,
    output logic [7:0]    op_count,
    output logic          busy
);
    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic        v1;
    logic        v2;
    logic [15:0] d1;
    logic [3:0]  amt1;
    logic [1:0]  op1;
    logic [15:0] data2;

    logic        adv1;
    logic        adv2;
    logic [3:0]  r;
    logic [15:0] rot;
    logic [15:0] mask;
    logic [15:0] res;

    // A stage may advance when it is empty or its successor is advancing.
    assign adv2 = !v2 || bus.out_ready;
    assign adv1 = !v1 || adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2;
    assign bus.out_data  = data2;
    assign busy          = v1 || v2;

    // ROL by n is ROR by (16 - n) mod 16, which is the 4-bit two's complement of n.
    assign r    = (op1 == OP_ROL) ? 4'd0 - amt1 : amt1;
    assign rot  = 16'({d1, d1} >> r);
    assign mask = 16'hFFFF >> amt1;

    // NOTE: res gets a default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        res = rot;
        case (op1)
            OP_SRL:  res = rot & mask;
            OP_SRA:  res = (rot & mask) | (~mask & {16{d1[15]}});
            OP_ROR,
            OP_ROL:  res = rot;
            default: res = rot;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            d1   <= '0;
            amt1 <= '0;
            op1  <= '0;
        end else if (adv1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                d1   <= bus.in_data;
                amt1 <= bus.in_amt;
                op1  <= bus.in_op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            data2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                data2 <= res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (v2 && bus.out_ready) begin
            op_count <= op_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_shift_pipe16.sv
// Directed self-checking bench for shift_pipe16: ops, boundaries, streaming,
// backpressure, mid-stream reset and counter wrap.
module tb_shift_pipe16;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] op_count;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    shift_pipe16_if bus ();

    shift_pipe16 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .op_count (op_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-by-bit reference, written independently of the rotate-and-mask datapath.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] a, input logic [1:0] op);
        logic [15:0] q;
        int s;
        for (int i = 0; i < 16; i++) begin
            s = i + int'(a);
            case (op)
                2'b00:   q[i] = d[4'(s % 16)];
                2'b01:   q[i] = d[4'((i - int'(a) + 16) % 16)];
                2'b10:   q[i] = (s < 16) ? d[4'(s)] : 1'b0;
                default: q[i] = (s < 16) ? d[4'(s)] : d[15];
            endcase
        end
        return q;
    endfunction

    task automatic drive(input logic [15:0] d, input logic [3:0] a, input logic [1:0] op);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_op    = op;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data: got %h expected 0000", bus.out_data); end
        checks++; if (op_count !== 8'h00) begin errors++; $display("FAIL rst_op_count: got %h expected 00", op_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_ops();
        logic [1:0]  ops [4];
        logic [15:0] exp [4];
        ops = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp = '{16'h1800, 16'h0018, 16'h0800, 16'hF800};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(16'h8001, 4'd4, ops[k]);
            tick();
            bus.in_valid = 1'b0;
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ops_early_valid[%0d]: got %b expected 0", k, bus.out_valid); end
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ops_valid[%0d]: got %b expected 1", k, bus.out_valid); end
            checks++; if (bus.out_data !== exp[k]) begin errors++; $display("FAIL ops_data[%0d]: got %h expected %h", k, bus.out_data, exp[k]); end
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ops_drained[%0d]: got %b expected 0", k, bus.out_valid); end
        end
        checks++; if (op_count !== 8'd4) begin errors++; $display("FAIL ops_count: got %0d expected 4", op_count); end
    endtask

    task automatic test_boundaries();
        logic [15:0] bd  [7];
        logic [3:0]  ba  [7];
        logic [1:0]  bo  [7];
        logic [15:0] be  [7];
        bit          found;
        bd = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h8000, 16'h8000, 16'h8000};
        ba = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15};
        bo = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01};
        be = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'hFFFF, 16'h0001, 16'h4000};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive(bd[k], ba[k], bo[k]);
            tick();
            bus.in_valid = 1'b0;
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                if (bus.out_valid === 1'b1) found = 1'b1;
                else tick();
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL bnd_timeout[%0d]: got no out_valid expected %h", k, be[k]);
            end else if (bus.out_data !== be[k]) begin
                errors++; $display("FAIL bnd_data[%0d]: got %h expected %h", k, bus.out_data, be[k]);
            end
            tick();
        end
    endtask

    task automatic test_streaming();
        logic [15:0] exp_q [$];
        logic [15:0] e;
        logic [15:0] d;
        logic [3:0]  a;
        logic [1:0]  op;
        int sent = 0, got = 0, first = -1, last = -1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 20; c++) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra: got %h expected nothing", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", got, bus.out_data, e); end
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            if (sent < 20) begin
                d  = 16'($urandom);
                a  = 4'($urandom_range(15));
                op = 2'($urandom_range(3));
                drive(d, a, op);
                exp_q.push_back(model(d, a, op));
                sent++;
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", sent, bus.in_ready); end
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 20 || last - first != 19) begin
            errors++; $display("FAIL stream_count: got %0d results over %0d cycles expected 20 over 20", got, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp [3];
        logic [15:0] seen [$];
        logic [7:0]  start;
        exp   = '{16'h000F, 16'h0F00, 16'hFF00};
        start = op_count;
        bus.out_ready = 1'b0;
        drive(16'h00F0, 4'd4, 2'b00);
        tick();
        drive(16'h00F0, 4'd4, 2'b01);
        tick();
        drive(16'hF000, 4'd4, 2'b11);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp[0] || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: got valid %b data %h ready %b expected 1 %h 0", c, bus.out_valid, bus.out_data, bus.in_ready, exp[0]);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid === 1'b1) seen.push_back(bus.out_data);
            tick();
            if (c == 0) bus.in_valid = 1'b0;
        end
        checks++;
        if (seen.size() != 3) begin
            errors++; $display("FAIL bp_drain_count: got %0d expected 3", seen.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (seen[k] !== exp[k]) begin errors++; $display("FAIL bp_drain[%0d]: got %h expected %h", k, seen[k], exp[k]); end
            end
        end
        checks++; if (op_count !== 8'(start + 8'd3)) begin errors++; $display("FAIL bp_count: got %0d expected %0d", op_count, 8'(start + 8'd3)); end
    endtask

    task automatic test_reset_midstream();
        bit found;
        bus.out_ready = 1'b0;
        drive(16'hABCD, 4'd3, 2'b00);
        tick();
        drive(16'h1357, 4'd5, 2'b10);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got busy %b valid %b ready %b expected 1 1 0", busy, bus.out_valid, bus.in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL mid_out_data: got %h expected 0000", bus.out_data); end
        checks++; if (op_count !== 8'h00) begin errors++; $display("FAIL mid_op_count: got %h expected 00", op_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        drive(16'h8001, 4'd4, 2'b10);
        tick();
        bus.in_valid = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 6 && !found; w++) begin
            if (bus.out_valid === 1'b1) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_after_timeout: got no out_valid expected 0800");
        end else if (bus.out_data !== 16'h0800) begin
            errors++; $display("FAIL mid_after_data: got %h expected 0800", bus.out_data);
        end
        tick();
        checks++; if (op_count !== 8'd1) begin errors++; $display("FAIL mid_after_count: got %0d expected 1", op_count); end
    endtask

    task automatic test_counter_wrap();
        int  acc = 0, xf = 0;
        bit  do_acc, do_xf;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 400 && xf < 256; c++) begin
            if (acc < 256) drive(16'(acc), 4'(acc), 2'(acc));
            else bus.in_valid = 1'b0;
            do_acc = bus.in_valid && bus.in_ready;
            do_xf  = bus.out_valid && bus.out_ready;
            tick();
            if (do_acc) acc++;
            if (do_xf) begin
                xf++;
                if (xf == 255) begin
                    checks++; if (op_count !== 8'hFF) begin errors++; $display("FAIL wrap_ff: got %h expected ff", op_count); end
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (xf != 256) begin errors++; $display("FAIL wrap_timeout: got %0d transfers expected 256", xf); end
        checks++; if (op_count !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %h expected 00", op_count); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_boundaries();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
